// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole input path.
// Provides the default button count, the matching index width, and a
// lowest-set-bit helper used by the press priority encoder.
package wam_pkg;

  localparam int unsigned N_BTN     = 8;
  localparam int unsigned BTN_IDX_W = $clog2(N_BTN);

  // Widest vector the priority helper accepts; callers zero-extend to this.
  localparam int unsigned VEC_MAX   = 32;

  // Index of the lowest set bit of vec, or 0 when vec is empty.
  function automatic int lowest_set(input logic [VEC_MAX-1:0] vec);
    int idx;
    idx = 0;
    for (int i = int'(VEC_MAX) - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-based debounce counter and
// debounced level register.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   raw        : asynchronous raw button level
//   tick       : debounce sample strobe from the shared prescaler
//   level      : debounced level (registered)
//   rise       : combinational; high when level is about to go 0->1 on the
//                next edge, so the parent can register press pulses in step
//                with level
module btn_debounce_ch #(
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);

  logic [1:0]       sync_q;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;

  assign sync = sync_q[1];

  // Metastability guard for the asynchronous pad input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], raw};
  end

  // Any agreeing cycle restarts the count, so only an unbroken run of
  // STABLE_TICKS mismatching ticks can flip the level.
  always_comb begin
    cnt_next   = cnt;
    level_next = level;
    if (sync == level) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt == CNT_W'(STABLE_TICKS - 1)) begin
        level_next = sync;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      level <= level_next;
    end
  end

  assign rise = level_next & ~level;

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner: debounces N_BTN raw buttons, emits one-cycle press
// pulses, queues presses in a pending mask and hands them out lowest index
// first over a valid/ready handshake.
// Ports:
//   clk, rst_n  : clock and async active-low reset
//   btn_raw     : raw asynchronous button levels
//   clr         : synchronous clear of pending mask and overflow
//   btn_level   : debounced levels
//   btn_press   : one-cycle pulse per debounced rising edge
//   press_valid : a press is pending (combinational from pending mask)
//   press_idx   : lowest pending index (combinational from pending mask)
//   press_ready : consumer takes press_idx this cycle
//   overflow    : sticky; a press hit an already-pending channel
module btn_conditioner #(
  parameter int unsigned N_BTN        = wam_pkg::N_BTN,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_raw,
  input  logic                     clr,
  output logic [N_BTN-1:0]         btn_level,
  output logic [N_BTN-1:0]         btn_press,
  output logic                     press_valid,
  output logic [$clog2(N_BTN)-1:0] press_idx,
  input  logic                     press_ready,
  output logic                     overflow
);

  import wam_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_BTN);
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] pending_next;
  logic [N_BTN-1:0] accept_mask;
  logic             overflow_next;

  // Debounce sample strobe; with TICK_DIV=1 the count sits at 0 and tick is
  // permanently high.
  assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRE_W'(1);
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[i]),
      .tick (tick),
      .level(btn_level[i]),
      .rise (rise[i])
    );
  end

  // Press pulse lands on the same edge that btn_level first reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_press <= '0;
    else        btn_press <= rise;
  end

  assign press_valid = |pending;
  assign press_idx   = IDX_W'(lowest_set(VEC_MAX'(pending)));

  // Accept and a new press on the same channel leave the bit set: the new
  // press is a distinct event and must still be delivered.
  always_comb begin
    accept_mask   = '0;
    if (press_valid && press_ready) accept_mask = N_BTN'(1) << press_idx;
    pending_next  = (pending & ~accept_mask) | rise;
    overflow_next = overflow | (|(rise & pending & ~accept_mask));
    if (clr) begin
      pending_next  = '0;
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: two instances (TICK_DIV=1/STABLE_TICKS=3 and
// TICK_DIV=4/STABLE_TICKS=2) share stimulus; each is compared every cycle
// against a behavioural model, plus directed literal checks.
module tb_btn_conditioner;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic         clr;
  logic         press_ready;

  int checks;
  int failures;
  bit chk_en;

  typedef struct packed {
    logic [31:0]        phase;
    logic [N-1:0]       h1;
    logic [N-1:0]       h2;
    logic [N-1:0]       lvl;
    logic [N-1:0]       press;
    logic [N-1:0]       pend;
    logic [N-1:0][7:0]  run;
    logic               ovf;
  } mstate_t;

  function automatic int lowest(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // One clock of the reference behaviour. run[i] counts ticks of unbroken
  // disagreement between the synchronised input and the accepted level.
  function automatic mstate_t step(input mstate_t s, input int unsigned td,
                                   input int unsigned st, input logic [N-1:0] raw,
                                   input logic rdy, input logic cl);
    mstate_t      n;
    logic         tk;
    logic [N-1:0] rises;
    logic [N-1:0] acc;
    n     = s;
    tk    = (s.phase == td - 1);
    n.phase = tk ? 32'd0 : s.phase + 32'd1;
    rises = '0;
    for (int i = 0; i < N; i++) begin
      if (s.h2[i] == s.lvl[i]) n.run[i] = 8'd0;
      else if (tk) begin
        if (int'(s.run[i]) + 1 == int'(st)) begin
          n.lvl[i]  = s.h2[i];
          n.run[i]  = 8'd0;
          rises[i]  = s.h2[i];
        end else begin
          n.run[i] = s.run[i] + 8'd1;
        end
      end
    end
    acc = '0;
    if (s.pend != 0 && rdy) acc[lowest(s.pend)] = 1'b1;
    if (cl) begin
      n.pend = '0;
      n.ovf  = 1'b0;
    end else begin
      n.pend = (s.pend & ~acc) | rises;
      n.ovf  = s.ovf | (|(rises & s.pend & ~acc));
    end
    n.press = rises;
    n.h2    = s.h1;
    n.h1    = raw;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int unsigned TD = (g == 0) ? 1 : 4;
    localparam int unsigned ST = (g == 0) ? 3 : 2;

    logic [N-1:0]  level;
    logic [N-1:0]  press;
    logic          valid;
    logic [IW-1:0] idx;
    logic          ovf;
    mstate_t       m;

    btn_conditioner #(
      .N_BTN(N), .TICK_DIV(TD), .STABLE_TICKS(ST)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .clr        (clr),
      .btn_level  (level),
      .btn_press  (press),
      .press_valid(valid),
      .press_idx  (idx),
      .press_ready(press_ready),
      .overflow   (ovf)
    );

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= step(m, TD, ST, btn_raw, press_ready, clr);
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("c%0d level", g), 32'(level), 32'(m.lvl));
        chk($sformatf("c%0d press", g), 32'(press), 32'(m.press));
        chk($sformatf("c%0d valid", g), 32'(valid), 32'(m.pend != 0));
        chk($sformatf("c%0d idx", g),   32'(idx),   32'(lowest(m.pend)));
        chk($sformatf("c%0d overflow", g), 32'(ovf), 32'(m.ovf));
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic settle();
    btn_raw = '0;
    repeat (14) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    checks = 0; failures = 0; chk_en = 0;
    btn_raw = '0; clr = 0; press_ready = 0; rst_n = 1;
    #2 rst_n = 0;
    #1 chk_en = 1;
    chk("reset level0", 32'(cfg[0].level), 0);
    chk("reset valid0", 32'(cfg[0].valid), 0);
    chk("reset idx0",   32'(cfg[0].idx),   0);
    chk("reset ovf1",   32'(cfg[1].ovf),   0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // clean press on channel 5
    @(negedge clk); btn_raw[5] = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("clean not yet", 32'(cfg[0].level[5]), 0);
    @(posedge clk);
    #1;
    chk("clean level", 32'(cfg[0].level), 32'h20);
    chk("clean press", 32'(cfg[0].press), 32'h20);
    chk("clean valid", 32'(cfg[0].valid), 1);
    chk("clean idx",   32'(cfg[0].idx),   5);
    @(posedge clk);
    #1 chk("clean pulse end", 32'(cfg[0].press), 0);
    @(negedge clk); press_ready = 1;
    @(negedge clk); press_ready = 0;
    chk("clean accepted", 32'(cfg[0].valid), 0);
    settle();

    // two-cycle glitch on channel 2
    @(negedge clk); btn_raw[2] = 1'b1;
    repeat (2) @(negedge clk); btn_raw[2] = 1'b0;
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      seen |= cfg[0].level[2] | cfg[0].press[2] | cfg[0].valid | cfg[1].level[2];
    end
    chk("glitch ignored", 32'(seen), 0);
    settle();

    // simultaneous presses on 6 and 1
    @(negedge clk); btn_raw = 8'h42;
    repeat (12) @(negedge clk);
    chk("simul first0", 32'(cfg[0].idx), 1);
    chk("simul first1", 32'(cfg[1].idx), 1);
    press_ready = 1; @(negedge clk); press_ready = 0;
    chk("simul second0", 32'(cfg[0].idx), 6);
    chk("simul second1", 32'(cfg[1].idx), 6);
    press_ready = 1; @(negedge clk); press_ready = 0;
    chk("simul drained0", 32'(cfg[0].valid), 0);
    chk("simul drained1", 32'(cfg[1].valid), 0);
    settle();

    // overflow on channel 3
    @(negedge clk); btn_raw[3] = 1'b1;
    repeat (12) @(negedge clk); btn_raw[3] = 1'b0;
    repeat (12) @(negedge clk); btn_raw[3] = 1'b1;
    repeat (12) @(negedge clk);
    chk("ovf set0",  32'(cfg[0].ovf), 1);
    chk("ovf set1",  32'(cfg[1].ovf), 1);
    chk("ovf idx",   32'(cfg[0].idx), 3);
    chk("ovf valid", 32'(cfg[0].valid), 1);
    clr = 1; @(negedge clk); clr = 0;
    chk("clr ovf",   32'(cfg[0].ovf), 0);
    chk("clr valid", 32'(cfg[0].valid), 0);
    settle();

    // prescaler latency on the TICK_DIV=4 instance
    @(negedge clk); btn_raw[2] = 1'b1;
    n = 0;
    while (cfg[1].level[2] !== 1'b1 && n < 14) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("presc latency n=%0d in 7..10", n), 32'(n >= 7 && n <= 10), 1);
    settle();

    // 3-cycle bounce is under 2 ticks at TICK_DIV=4
    @(negedge clk); btn_raw[4] = 1'b1;
    repeat (3) @(negedge clk); btn_raw[4] = 1'b0;
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      seen |= cfg[1].level[4] | cfg[1].press[4];
    end
    chk("presc bounce", 32'(seen), 0);
    settle();

    // reset with pending 8'h21 and channel 7 mid-count
    @(negedge clk); btn_raw = 8'h21;
    repeat (12) @(negedge clk);
    chk("pre-reset valid", 32'(cfg[0].valid), 1);
    chk("pre-reset idx",   32'(cfg[0].idx),   0);
    btn_raw[7] = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async rst level", 32'(cfg[0].level), 0);
    chk("async rst press", 32'(cfg[0].press), 0);
    chk("async rst valid", 32'(cfg[0].valid), 0);
    chk("async rst idx",   32'(cfg[0].idx),   0);
    chk("async rst level1", 32'(cfg[1].level), 0);
    @(negedge clk); rst_n = 1;
    repeat (4) @(posedge clk);
    #1 chk("re-debounce early", 32'(cfg[0].level), 0);
    @(posedge clk);
    #1;
    chk("re-debounce level", 32'(cfg[0].level), 32'hA1);
    chk("re-debounce press", 32'(cfg[0].press), 32'hA1);
    chk("re-debounce idx",   32'(cfg[0].idx),   0);
    settle();

    // randomized traffic
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) btn_raw[i] = ~btn_raw[i];
      press_ready = ($urandom_range(0, 3) == 0);
      clr         = ($urandom_range(0, 199) == 0);
    end
    clr = 0; press_ready = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
